// File: rtl/wb2sdrc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb2sdrc_pkg
// Purpose  : Shared constants and FSM encoding for the wb2sdrc_burst bridge.
// Revision : 1.0
// ============================================================================
package wb2sdrc_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WCOLLECT = 3'd1,
    ST_WREQ     = 3'd2,
    ST_RREQ     = 3'd3,
    ST_RDATA    = 3'd4,
    ST_RFLUSH   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO; the head entry is always on dout.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A pop while full frees the slot only on the next cycle; no bypass path.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && full)  $warning("sync_fifo: push while full ignored");
      if (pop && empty)  $warning("sync_fifo: pop while empty ignored");
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/wb2sdrc_burst.sv
`default_nettype none
// ============================================================================
// Module   : wb2sdrc_burst
// Purpose  : Single-clock Wishbone to SDRAM-controller bridge with
//            incrementing-burst write gathering and read prefetch.
// Revision : 1.0
// ============================================================================
module wb2sdrc_burst
  import wb2sdrc_pkg::*;
#(
  parameter int dw        = 32,
  parameter int bl        = 9,
  parameter int max_burst = 8,
  parameter int wr_depth  = 16,
  parameter int rd_depth  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  input  logic             wb_we_i,
  input  logic [29:0]      wb_addr_i,
  input  logic [dw-1:0]    wb_dat_i,
  input  logic [dw/8-1:0]  wb_sel_i,
  input  logic [2:0]       wb_cti_i,
  output logic             wb_ack_o,
  output logic [dw-1:0]    wb_dat_o,
  output logic             sdr_req,
  output logic [29:0]      sdr_req_addr,
  output logic [bl-1:0]    sdr_req_len,
  output logic             sdr_req_wr_n,
  input  logic             sdr_req_ack,
  output logic [dw/8-1:0]  sdr_wr_en_n,
  output logic [dw-1:0]    sdr_wr_data,
  input  logic             sdr_wr_next,
  input  logic             sdr_rd_valid,
  input  logic             sdr_last_rd,
  input  logic [dw-1:0]    sdr_rd_data
);

  localparam int              sw         = dw/8;
  localparam int              WCW        = $clog2(wr_depth+1);
  localparam int              RCW        = $clog2(rd_depth+1);
  localparam logic [bl-1:0]   c_max_len  = bl'(max_burst);
  localparam logic [29:0]     c_max_step = 30'(max_burst);

  state_t          r_state;
  logic [29:0]     r_addr;
  logic [bl-1:0]   r_len;
  logic [bl-1:0]   r_cnt;
  logic            r_req;
  logic            r_wr_n;
  logic            r_wcont;
  logic            r_last_seen;

  logic            w_access, w_incr, w_wr_ack, w_rd_ack, w_rpop;
  logic            w_wfull, w_wempty, w_rfull, w_rempty;
  logic            w_rd_end, w_rd_more;
  logic [WCW-1:0]  w_wcount;
  logic [RCW-1:0]  w_rcount;
  logic [bl-1:0]   w_cnt_inc;
  logic [dw+sw-1:0] w_whead;
  logic [dw:0]     w_rhead;
  logic            w_unused;

  assign w_access  = wb_stb_i & wb_cyc_i;
  assign w_incr    = (wb_cti_i == CTI_INCR);
  assign w_cnt_inc = r_cnt + bl'(1);
  assign w_wr_ack  = ~wb_rst_i & w_access & wb_we_i & ~w_wfull &
                     ((r_state == ST_IDLE) | (r_state == ST_WCOLLECT));
  assign w_rd_ack  = ~wb_rst_i & w_access & ~w_rempty & (r_state == ST_RDATA);
  assign w_rpop    = w_rd_ack | (~wb_rst_i & ~w_rempty & (r_state == ST_RFLUSH));
  assign w_rd_end  = ~wb_cyc_i | (w_rd_ack & ~w_incr);
  // Beats still queued or still in flight mean the burst must be drained.
  assign w_rd_more = ~r_last_seen | sdr_rd_valid | (w_rcount > RCW'(w_rd_ack));
  assign w_unused  = &{1'b0, w_rfull, w_wcount};

  assign wb_ack_o     = w_wr_ack | w_rd_ack;
  assign wb_dat_o     = w_rd_ack ? w_rhead[dw-1:0] : '0;
  assign sdr_req      = r_req;
  assign sdr_req_addr = r_addr;
  assign sdr_req_len  = r_len;
  assign sdr_req_wr_n = r_wr_n;
  assign sdr_wr_en_n  = w_wempty ? '1 : w_whead[dw+sw-1:dw];
  assign sdr_wr_data  = w_wempty ? '0 : w_whead[dw-1:0];

  sync_fifo #(.WIDTH(dw+sw), .DEPTH(wr_depth)) u_wr_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(w_wr_ack), .din({~wb_sel_i, wb_dat_i}),
    .pop(sdr_wr_next), .dout(w_whead),
    .full(w_wfull), .empty(w_wempty), .count(w_wcount)
  );

  sync_fifo #(.WIDTH(dw+1), .DEPTH(rd_depth)) u_rd_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(sdr_rd_valid), .din({sdr_last_rd, sdr_rd_data}),
    .pop(w_rpop), .dout(w_rhead),
    .full(w_rfull), .empty(w_rempty), .count(w_rcount)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_wr_n      <= 1'b1;
      r_wcont     <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      if (sdr_rd_valid && sdr_last_rd) r_last_seen <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ack) begin
            // A burst split at max_burst resumes where the previous chunk ended.
            r_addr  <= r_wcont ? r_addr + c_max_step : wb_addr_i;
            r_wcont <= 1'b0;
            r_cnt   <= bl'(1);
            if (w_incr && max_burst > 1) begin
              r_state <= ST_WCOLLECT;
            end else begin
              r_state <= ST_WREQ;
              r_req   <= 1'b1;
              r_wr_n  <= 1'b0;
              r_len   <= bl'(1);
            end
          end else if (w_access && !wb_we_i) begin
            r_addr      <= wb_addr_i;
            r_wcont     <= 1'b0;
            r_req       <= 1'b1;
            r_wr_n      <= 1'b1;
            r_len       <= w_incr ? c_max_len : bl'(1);
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_state     <= ST_RREQ;
          end else if (!wb_cyc_i) begin
            r_wcont <= 1'b0;
          end
        end
        ST_WCOLLECT: begin
          if (w_wr_ack) begin
            r_cnt <= w_cnt_inc;
            if (!w_incr || w_cnt_inc == c_max_len) begin
              r_state <= ST_WREQ;
              r_req   <= 1'b1;
              r_wr_n  <= 1'b0;
              r_len   <= w_cnt_inc;
              r_wcont <= w_incr;
            end
          end else if (!wb_cyc_i) begin
            r_state <= ST_WREQ;
            r_req   <= 1'b1;
            r_wr_n  <= 1'b0;
            r_len   <= r_cnt;
          end
        end
        ST_WREQ: begin
          if (sdr_req_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RREQ: begin
          if (sdr_req_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (w_rd_ack) r_cnt <= w_cnt_inc;
          if (w_rd_end) begin
            r_state <= w_rd_more ? ST_RFLUSH : ST_IDLE;
          end else if (w_rd_ack && w_cnt_inc == c_max_len) begin
            r_addr      <= r_addr + c_max_step;
            r_req       <= 1'b1;
            r_wr_n      <= 1'b1;
            r_len       <= c_max_len;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_state     <= ST_RREQ;
          end
        end
        ST_RFLUSH: begin
          if (!w_rempty && w_rhead[dw] && w_rcount == RCW'(1))
            r_state <= ST_IDLE;
          else if (w_rempty && r_last_seen)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb2sdrc_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb2sdrc_burst
// Purpose  : Self-checking bench for wb2sdrc_burst with a request scoreboard.
// Revision : 1.0
// ============================================================================
module tb_wb2sdrc_burst;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [29:0] wb_addr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [2:0]  wb_cti_i = '0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        sdr_req, sdr_req_wr_n;
  logic [29:0] sdr_req_addr;
  logic [8:0]  sdr_req_len;
  logic        sdr_req_ack = 1'b0;
  logic [3:0]  sdr_wr_en_n;
  logic [31:0] sdr_wr_data;
  logic        sdr_wr_next = 1'b0;
  logic        sdr_rd_valid = 1'b0, sdr_last_rd = 1'b0;
  logic [31:0] sdr_rd_data = '0;

  wb2sdrc_burst dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_cti_i(wb_cti_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .sdr_req(sdr_req),
    .sdr_req_addr(sdr_req_addr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_req_ack(sdr_req_ack),
    .sdr_wr_en_n(sdr_wr_en_n), .sdr_wr_data(sdr_wr_data),
    .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
    .sdr_last_rd(sdr_last_rd), .sdr_rd_data(sdr_rd_data)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [29:0] addr;
    logic [8:0]  len;
    logic        wr_n;
  } req_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [3:0]  en_n;
    logic [31:0] rdat;
  } vec_t;

  int          ntotal = 0;
  int          nbad   = 0;
  req_t        exp_req[$];
  logic [35:0] wq[$];
  bit          drain_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return (a == 30'h40) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // SDRAM controller model: checks each request against the scoreboard.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (sdr_req && !wb_rst_i) begin
        req_t got;
        req_t want;
        got = '{addr: sdr_req_addr, len: sdr_req_len, wr_n: sdr_req_wr_n};
        if (exp_req.size() == 0) begin
          ntotal++; nbad++;
          $display("FAIL unexpected_req actual=%h required=none", got);
        end else begin
          want = exp_req.pop_front();
          chk("sdr_req", 64'(got), 64'(want));
        end
        sdr_req_ack = 1'b1;
        @(posedge wb_clk_i); #1;
        sdr_req_ack = 1'b0;
        if (got.wr_n) begin
          for (int i = 0; i < int'(got.len); i++) begin
            sdr_rd_valid = 1'b1;
            sdr_rd_data  = mem_word(got.addr + 30'(i));
            sdr_last_rd  = (i == int'(got.len) - 1);
            @(posedge wb_clk_i); #1;
          end
          sdr_rd_valid = 1'b0;
          sdr_last_rd  = 1'b0;
        end
      end
    end
  end

  // Write-data drain: compares the FIFO head with the expected beat, then pops.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (drain_en && wq.size() > 0 && !wb_rst_i) begin
        chk("wr_head", 64'({sdr_wr_en_n, sdr_wr_data}), 64'(wq.pop_front()));
        sdr_wr_next = 1'b1;
        @(posedge wb_clk_i); #1;
        sdr_wr_next = 1'b0;
      end
    end
  end

  task automatic beat(input logic we, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] cti,
                      output logic [31:0] rd, output bit ok);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = a; wb_dat_i = d; wb_sel_i = s; wb_cti_i = cti;
    ok = 1'b0; rd = '0;
    for (int t = 0; t < 300; t++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o) begin ok = 1'b1; rd = wb_dat_o; break; end
    end
    if (!ok) begin
      ntotal++; nbad++;
      $display("FAIL ack_timeout actual=no_ack required=ack addr=%h", a);
    end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wr_burst(input logic [29:0] a, input int n, input int stall_at, output int nack);
    logic [31:0] rd;
    bit ok;
    nack = 0;
    for (int i = 0; i < n; i++) begin
      logic [2:0]  cti;
      logic [31:0] d;
      cti = (i == n - 1) ? 3'b111 : 3'b010;
      d   = {2'b01, a + 30'(i)};
      if (i == stall_at) begin
        bit saw;
        saw = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_addr_i = a + 30'(i); wb_dat_i = d; wb_sel_i = 4'hF; wb_cti_i = cti;
        repeat (6) begin
          @(negedge wb_clk_i);
          if (wb_ack_o) saw = 1'b1;
        end
        chk("full_hold_ack", 64'(saw), 64'd0);
        drain_en = 1'b1;
      end
      beat(1'b1, a + 30'(i), d, 4'hF, cti, rd, ok);
      if (ok) begin
        nack++;
        wq.push_back({4'h0, d});
      end
    end
    idle_bus();
  endtask

  task automatic wait_drained();
    for (int t = 0; t < 400; t++) begin
      if (wq.size() == 0 && exp_req.size() == 0) break;
      @(posedge wb_clk_i); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [31:0] rd;
    bit          ok;
    int          nack;

    tbl[0] = '{1'b1, 30'h100,      32'hA5A5A5A5, 4'b0011, 4'b1100, 32'h0};
    tbl[1] = '{1'b0, 30'h40,       32'h0,        4'hF,    4'hF,    32'hDEADBEEF};
    tbl[2] = '{1'b1, 30'h104,      32'h12345678, 4'b1000, 4'b0111, 32'h0};
    tbl[3] = '{1'b1, 30'h3FFFFFFF, 32'hFFFFFFFF, 4'b1111, 4'b0000, 32'h0};
    tbl[4] = '{1'b0, 30'h3FFFFFFF, 32'h0,        4'hF,    4'hF,    32'hFFFF0000};
    tbl[5] = '{1'b0, 30'h7,        32'h0,        4'hF,    4'hF,    32'h0007FFF8};

    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_req",    64'(sdr_req),      64'd0);
    chk("rst_ack",    64'(wb_ack_o),     64'd0);
    chk("rst_en_n",   64'(sdr_wr_en_n),  64'hF);
    chk("rst_len",    64'(sdr_req_len),  64'd0);
    chk("rst_addr",   64'(sdr_req_addr), 64'd0);
    chk("rst_wr_n",   64'(sdr_req_wr_n), 64'd1);
    chk("rst_dat",    64'(wb_dat_o),     64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;

    // Classic single-beat table.
    drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_req.push_back('{addr: tbl[i].addr, len: 9'd1, wr_n: ~tbl[i].we});
      beat(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sel, 3'b000, rd, ok);
      if (ok && tbl[i].we) wq.push_back({tbl[i].en_n, tbl[i].data});
      if (ok && !tbl[i].we) chk("tbl_rdata", 64'(rd), 64'(tbl[i].rdat));
      idle_bus();
    end

    exp_req.push_back('{addr: 30'h200, len: 9'd8, wr_n: 1'b0});
    wr_burst(30'h200, 8, -1, nack);
    chk("b8_acks", 64'(nack), 64'd8);

    exp_req.push_back('{addr: 30'h300, len: 9'd8, wr_n: 1'b0});
    exp_req.push_back('{addr: 30'h308, len: 9'd4, wr_n: 1'b0});
    wr_burst(30'h300, 12, -1, nack);
    chk("b12_acks", 64'(nack), 64'd12);

    // Incrementing read of 3 beats against an 8-beat prefetch.
    exp_req.push_back('{addr: 30'h80, len: 9'd8, wr_n: 1'b1});
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 30'h80 + 30'(i), 32'h0, 4'hF, (i == 2) ? 3'b111 : 3'b010, rd, ok);
      if (ok) chk("incr_rdata", 64'(rd), 64'({16'h0080 + 16'(i), ~(16'h0080 + 16'(i))}));
    end
    idle_bus();
    exp_req.push_back('{addr: 30'h90, len: 9'd1, wr_n: 1'b1});
    beat(1'b0, 30'h90, 32'h0, 4'hF, 3'b000, rd, ok);
    if (ok) chk("post_flush_rdata", 64'(rd), 64'h0090FF6F);
    idle_bus();

    // Write FIFO fills during a 20-beat burst with the drain held off.
    wait_drained();
    drain_en = 1'b0;
    exp_req.push_back('{addr: 30'h400, len: 9'd8, wr_n: 1'b0});
    exp_req.push_back('{addr: 30'h408, len: 9'd8, wr_n: 1'b0});
    exp_req.push_back('{addr: 30'h410, len: 9'd4, wr_n: 1'b0});
    wr_burst(30'h400, 20, 16, nack);
    chk("b20_acks", 64'(nack), 64'd20);
    wait_drained();

    // Reset in the middle of a write burst.
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 30'h500 + 30'(i), 32'hCAFE0000 + 32'(i), 4'hF, 3'b010, rd, ok);
    end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("mid_rst_req",  64'(sdr_req),      64'd0);
    chk("mid_rst_ack",  64'(wb_ack_o),     64'd0);
    chk("mid_rst_en_n", 64'(sdr_wr_en_n),  64'hF);
    chk("mid_rst_len",  64'(sdr_req_len),  64'd0);
    chk("mid_rst_addr", 64'(sdr_req_addr), 64'd0);
    chk("mid_rst_wr_n", 64'(sdr_req_wr_n), 64'd1);
    chk("mid_rst_dat",  64'(wb_dat_o),     64'd0);
    idle_bus();
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    drain_en = 1'b1;
    exp_req.push_back('{addr: 30'h600, len: 9'd1, wr_n: 1'b0});
    beat(1'b1, 30'h600, 32'h600D600D, 4'b0101, 3'b000, rd, ok);
    if (ok) wq.push_back({4'b1010, 32'h600D600D});
    idle_bus();

    wait_drained();
    repeat (10) @(posedge wb_clk_i);
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("wdata_queue_empty", 64'(wq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb2sdrc_burst.md
Name: wb2sdrc_burst

Overview:
Single-clock successor to the Wishbone-to-SDRAM-controller translator. It is used where the Wishbone and SDRAM controller share one clock, so there is no CDC. It adds incrementing-burst support (wb_cti_i = 3'b010) in both directions: write beats are gathered into one multi-beat SDRAM request, and burst reads are prefetched. Data width and FIFO depths are parametrised. It sits between the Wishbone interconnect and the SDRAM controller request port.

Parameters:
dw, 32, data width (multiple of 8)
bl, 9, width of sdr_req_len
max_burst, 8, maximum beats per SDRAM request (1..2^bl-1)
wr_depth, 16, write FIFO depth (power of 2, >= max_burst)
rd_depth, 16, read FIFO depth (power of 2, >= max_burst)

Ports:
wb_clk_i  in  1  clock, shared by Wishbone and SDRAM controller
wb_rst_i  in  1  reset, synchronous, active-high
wb_stb_i  in  1  Wishbone strobe
wb_cyc_i  in  1  Wishbone cycle
wb_we_i  in  1  1 = write, 0 = read
wb_addr_i  in  30  word address
wb_dat_i  in  dw  write data
wb_sel_i  in  dw/8  byte enables
wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst; 001 is treated as classic
wb_ack_o  out  1  Wishbone acknowledge
wb_dat_o  out  dw  read data
sdr_req  out  1  request valid
sdr_req_addr  out  30  start word address
sdr_req_len  out  bl  beat count, 1..max_burst (no minus-one encoding)
sdr_req_wr_n  out  1  0 = write, 1 = read
sdr_req_ack  in  1  request accepted
sdr_wr_en_n  out  dw/8  active-low byte enables of the write FIFO head
sdr_wr_data  out  dw  write FIFO head data
sdr_wr_next  in  1  pop write FIFO
sdr_rd_valid  in  1  read beat valid
sdr_last_rd  in  1  last beat of the read burst
sdr_rd_data  in  dw  read data

Behaviour:
- Reset: FSM = IDLE, both FIFOs empty, counters = 0. Output values under reset: sdr_req = 0, wb_ack_o = 0, sdr_wr_en_n = all ones, sdr_req_len = 0, sdr_req_addr = 0, sdr_req_wr_n = 1, wb_dat_o = 0.
- A reset asserted mid-operation abandons in-flight bursts; the SDRAM controller is reset alongside.
- Access = wb_stb_i & wb_cyc_i. Direction and start address are latched on the first beat of a burst.
- FSM states: IDLE, WCOLLECT, WREQ, RREQ, RDATA, RFLUSH.
- IDLE, write access: ack the beat if the write FIFO is not full, push {~wb_sel_i, wb_dat_i}, set beat count = 1. Then:
  - WCOLLECT if cti = 010 and max_burst > 1;
  - otherwise WREQ.
- WCOLLECT:
  - Ack and push each access while the FIFO is not full; increment the count.
  - Go to WREQ after an accepted beat with cti != 010, when the count reaches max_burst, or when wb_cyc_i drops (use the count so far).
  - Stalls (stb low, or FIFO full) hold the state.
- WREQ: sdr_req = 1 with the latched address, len = count, wr_n = 0. Hold until sdr_req_ack, then go to IDLE.
  - If the master's burst continues past max_burst, the next beat starts a new burst at latched address + max_burst.
  - The write FIFO drains independently through sdr_wr_next. sdr_wr_data and sdr_wr_en_n always show the FIFO head (show-ahead).
- IDLE, read access: go to RREQ with len = max_burst if cti = 010, else 1.
- RREQ: sdr_req = 1, wr_n = 1, held until sdr_req_ack, then go to RDATA. sdr_rd_valid pushes {sdr_last_rd, sdr_rd_data}.
- RDATA:
  - wb_ack_o = access & FIFO not empty. wb_dat_o = FIFO head; an ack pops the FIFO.
  - Count consumed beats.
  - If an acked beat has cti != 010, or wb_cyc_i drops: go to RFLUSH if the FIFO still holds beats or sdr_last_rd has not yet been seen; otherwise go to IDLE.
  - If consumed = max_burst while the master still issues cti = 010, go to RREQ at address + max_burst.
- RFLUSH: no ack. Pop and discard beats until the popped entry has last = 1 and the FIFO is empty, then go to IDLE.
- Only one read request is outstanding at a time, so the read FIFO never overflows (rd_depth >= max_burst).
- Write ack is combinational on FIFO state, with zero added latency. Read ack arrives at the earliest on the cycle after the first sdr_rd_valid.
- Simultaneous push and pop on either FIFO is legal, including when full or empty (pop-when-full frees a slot next cycle; no same-cycle bypass).
- Overflow/underflow (push when full, pop when empty) is ignored and flagged by a simulation-only message.

Decomposition:
- Package wb2sdrc_pkg: CTI constants (CTI_CLASSIC, CTI_CONST, CTI_INCR, CTI_EOB) and the FSM state encoding.
- One sub-module, sync_fifo (show-ahead, parametrised width/depth, full/empty, count), instantiated for the write path and the read path.

Test Plan:
- Single classic write, addr 0x100, data 0xA5A5A5A5, sel 4'b0011 -> one request, len 1, wr_n 0, addr 0x100; sdr_wr_en_n = 4'b1100 at the FIFO head.
- Incrementing write of 8 beats at 0x200 (cti 010 x7 then 111), max_burst 8 -> 8 acks, exactly one request with len 8; 8 pops in order.
- Incrementing write of 12 beats, max_burst 8 -> requests (0x300, len 8) then (0x308, len 4).
- Classic read at 0x40, controller returns 0xDEADBEEF with last -> one ack with wb_dat_o = 0xDEADBEEF; no further request.
- Incrementing read of 3 beats (cti 010, 010, 111) with 8 beats prefetched -> 3 acks, RFLUSH discards 5, back in IDLE; the next read issues a fresh request.
- Write FIFO full (wr_depth 16, sdr_wr_next held low) during a 20-beat burst -> ack withheld after the 16th beat until sdr_wr_next pulses; no data lost. Reset mid-burst -> all outputs return to reset values on the next edge.
